// File: rtl/pri_enc_pkg.sv
// Shared types and helpers for the pri_enc_arb arbiter.
//   state_t  : arbiter FSM state (IDLE, GRANT)
//   hsb_idx  : index of the highest set bit of a vector of up to 32 bits
//              (returns 0 for an all-zero vector)
package pri_enc_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam int MAX_N = 32;

   function automatic logic [4:0] hsb_idx(input logic [MAX_N-1:0] v);
      logic [4:0] r;
      r = '0;
      for (int i = 0; i < MAX_N; i++) begin
         if (v[i]) r = 5'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/pri_enc_core.sv
// Combinational highest-set-bit encoder, parametrised on vector width.
// Ports:
//   i_vec : N-bit input vector
//   o_idx : W-bit index of the highest set bit (0 when i_vec is zero)
//   o_any : reduction-OR of i_vec
module pri_enc_core
   import pri_enc_pkg::*;
#(
   parameter  int N = 8,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] i_vec,
   output logic [W-1:0] o_idx,
   output logic         o_any
);

   logic [4:0] w_hsb;

   assign w_hsb = hsb_idx(MAX_N'(i_vec));
   // Only bits below N can be set, so the result always fits in W bits.
   assign o_idx = w_hsb[W-1:0];
   assign o_any = |i_vec;

endmodule

// File: rtl/pri_enc_arb.sv
// Registered priority arbiter with one-hot and binary grant outputs.
// Build option: define PRI_ENC_ARB_RR_EN for round-robin arbitration
// (last winner gets lowest priority); otherwise fixed priority, highest
// index wins.
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   req     : N-bit request vector
//   ack     : consumer accepts the current grant
//   valid   : a grant is being presented
//   gnt_idx : binary index of the granted requester
//   gnt_oh  : one-hot grant, zero when valid=0
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | no grant presented; any request loads a winner
// GRANT | grant held until ack; ack re-arbitrates or returns IDLE
module pri_enc_arb
   import pri_enc_pkg::*;
#(
   parameter  int N = 8,
   localparam int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         ack,
   output logic         valid,
   output logic [W-1:0] gnt_idx,
   output logic [N-1:0] gnt_oh
);

   state_t         r_state;
   state_t         w_state_nxt;
   logic           w_load;
   logic [W-1:0]   r_idx;
   logic [N-1:0]   r_oh;
   logic [N-1:0]   w_search;
   logic [W-1:0]   w_enc;
   logic [W-1:0]   w_win;
   logic           w_any;

   pri_enc_core #(.N(N)) u_core (
      .i_vec (w_search),
      .o_idx (w_enc),
      .o_any (w_any)
   );

`ifdef PRI_ENC_ARB_RR_EN
   logic [W-1:0] r_ptr;

   // Rotate so that bit N-1 of the search vector is requester ptr-1 and
   // bit 0 is requester ptr itself; the encoder's highest bit then walks
   // downward from ptr-1 with wrap, leaving the last winner for last.
   always_comb begin
      w_search = '0;
      for (int j = 0; j < N; j++) begin
         int t;
         t = int'(r_ptr) + j;
         if (t >= N) t = t - N;
         w_search[j] = req[t[W-1:0]];
      end
   end

   always_comb begin
      int s;
      s = int'(r_ptr) + int'(w_enc);
      if (s >= N) s = s - N;
      w_win = s[W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst)         r_ptr <= W'(N-1);
      else if (w_load) r_ptr <= w_win;
   end
`else
   assign w_search = req;
   assign w_win    = w_enc;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_state_nxt = GRANT;
               w_load      = 1'b1;
            end
         end
         GRANT: begin
            if (ack) begin
               if (w_any) w_load = 1'b1;
               else       w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_oh    <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load) begin
            r_idx <= w_win;
            r_oh  <= N'(1) << w_win;
         end else if (w_state_nxt == IDLE) begin
            r_idx <= '0;
            r_oh  <= '0;
         end
      end
   end

   assign valid   = (r_state == GRANT);
   assign gnt_idx = r_idx;
   assign gnt_oh  = r_oh;

endmodule

// File: tb/tb_pri_enc_arb.sv
module tb_pri_enc_arb;

   logic       clk = 1'b0;
   logic       rst, ack, rst5, ack5;
   logic [7:0] req;
   logic [4:0] req5;
   logic       valid, valid5;
   logic [2:0] gnt_idx, gnt_idx5;
   logic [7:0] gnt_oh;
   logic [4:0] gnt_oh5;

   int total = 0;
   int bad   = 0;

   // reference model state for the N=8 instance
   logic       m_valid;
   logic [2:0] m_idx;
   logic [2:0] m_ptr;

   always #5 clk = ~clk;

   pri_enc_arb #(.N(8)) dut (
      .clk(clk), .rst(rst), .req(req), .ack(ack),
      .valid(valid), .gnt_idx(gnt_idx), .gnt_oh(gnt_oh)
   );

   pri_enc_arb #(.N(5)) dut5 (
      .clk(clk), .rst(rst5), .req(req5), .ack(ack5),
      .valid(valid5), .gnt_idx(gnt_idx5), .gnt_oh(gnt_oh5)
   );

   function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] p);
      logic [2:0] w;
      logic       found;
      w = 3'd0;
      found = 1'b0;
`ifdef PRI_ENC_ARB_RR_EN
      for (int k = 1; k <= 8; k++) begin
         int i;
         i = (int'(p) - k + 8) % 8;
         if (!found && r[i]) begin w = 3'(i); found = 1'b1; end
      end
`else
      for (int i = 7; i >= 0; i--) begin
         if (!found && r[i]) begin w = 3'(i); found = 1'b1; end
      end
`endif
      return w;
   endfunction

   function automatic logic [7:0] exp_oh();
      return m_valid ? (8'd1 << m_idx) : 8'd0;
   endfunction

   // advance the model by the edge about to happen, then take that edge
   task automatic step();
      if (rst) begin
         m_valid = 1'b0; m_idx = 3'd0; m_ptr = 3'd7;
      end else if (!m_valid || ack) begin
         if (req != 8'd0) begin
            m_valid = 1'b1;
            m_idx   = pick(req, m_ptr);
            m_ptr   = m_idx;
         end else begin
            m_valid = 1'b0;
            m_idx   = 3'd0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic go_idle();
      req = 8'd0; ack = 1'b1; rst = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1; ack = 1'b1; req = 8'hFF;
      rst5 = 1'b1; ack5 = 1'b0; req5 = 5'd0;
      step(); step();
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
      total++; if (gnt_idx !== 3'd0) begin bad++; $display("FAIL reset_idx got=%0d want=0", gnt_idx); end
      total++; if (gnt_oh !== 8'd0) begin bad++; $display("FAIL reset_oh got=%b want=0", gnt_oh); end
      total++; if ({valid5, gnt_idx5, gnt_oh5} !== 9'd0) begin bad++; $display("FAIL reset_n5 got=%b want=0", {valid5, gnt_idx5, gnt_oh5}); end
      rst = 1'b0; rst5 = 1'b0; req = 8'd0;
   endtask

   task automatic test_idle();
      req = 8'd0; ack = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         total++; if (valid !== 1'b0) begin bad++; $display("FAIL idle_valid cyc=%0d got=%b want=0", c, valid); end
         total++; if (gnt_oh !== 8'd0) begin bad++; $display("FAIL idle_oh cyc=%0d got=%b want=0", c, gnt_oh); end
      end
   endtask

`ifndef PRI_ENC_ARB_RR_EN
   task automatic test_fixed_starve();
      go_idle();
      req = 8'b1000_0001; ack = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         total++; if (valid !== 1'b1 || gnt_idx !== 3'd7) begin bad++; $display("FAIL fixed_starve cyc=%0d got=%b/%0d want=1/7", c, valid, gnt_idx); end
      end
   endtask
`else
   task automatic test_rr_sweep();
      logic [2:0] seq [9] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
      go_idle();
      req = 8'h01; ack = 1'b1;  // leaves the pointer at 0
      step();
      total++; if (gnt_idx !== 3'd0) begin bad++; $display("FAIL rr_seed got=%0d want=0", gnt_idx); end
      req = 8'hFF;
      for (int c = 0; c < 9; c++) begin
         step();
         total++; if (valid !== 1'b1 || gnt_idx !== seq[c]) begin bad++; $display("FAIL rr_sweep cyc=%0d got=%b/%0d want=1/%0d", c, valid, gnt_idx, seq[c]); end
      end
   endtask
`endif

   task automatic test_hold();
      go_idle();
      req = 8'b0000_0100; ack = 1'b0;
      step();
      total++; if (gnt_idx !== 3'd2 || valid !== 1'b1) begin bad++; $display("FAIL hold_first got=%b/%0d want=1/2", valid, gnt_idx); end
      req = 8'b0100_0000;
      for (int c = 0; c < 3; c++) begin
         step();
         total++; if (gnt_idx !== 3'd2 || gnt_oh !== 8'b0000_0100) begin bad++; $display("FAIL hold_stable cyc=%0d got=%0d/%b want=2/00000100", c, gnt_idx, gnt_oh); end
      end
      ack = 1'b1;
      step();
      total++; if (gnt_idx !== 3'd6 || gnt_oh !== 8'b0100_0000) begin bad++; $display("FAIL hold_next got=%0d/%b want=6/01000000", gnt_idx, gnt_oh); end
      req = 8'd0;
      step();
      total++; if (valid !== 1'b0 || gnt_oh !== 8'd0) begin bad++; $display("FAIL hold_release got=%b/%b want=0/0", valid, gnt_oh); end
   endtask

   task automatic test_reset_mid();
      go_idle();
      req = 8'h10; ack = 1'b0;
      step();
      total++; if (valid !== 1'b1) begin bad++; $display("FAIL mid_pre got=%b want=1", valid); end
      rst = 1'b1; ack = 1'b1;
      step();
      total++; if (valid !== 1'b0 || gnt_idx !== 3'd0 || gnt_oh !== 8'd0) begin bad++; $display("FAIL mid_rst got=%b/%0d/%b want=0/0/0", valid, gnt_idx, gnt_oh); end
      rst = 1'b0;
      step();
      total++; if (valid !== 1'b1 || gnt_idx !== 3'd4) begin bad++; $display("FAIL mid_after got=%b/%0d want=1/4", valid, gnt_idx); end
   endtask

   task automatic test_n5();
      req5 = 5'b10000; ack5 = 1'b0;
      step();
      total++; if (gnt_idx5 !== 3'd4 || gnt_oh5 !== 5'b10000 || valid5 !== 1'b1) begin bad++; $display("FAIL n5_grant got=%b/%0d/%b want=1/4/10000", valid5, gnt_idx5, gnt_oh5); end
      total++; if ($isunknown({valid5, gnt_idx5, gnt_oh5})) begin bad++; $display("FAIL n5_x got=%b want=no X", {valid5, gnt_idx5, gnt_oh5}); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 39) == 0);
         ack = $urandom_range(0, 1) == 1;
         req = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom & $urandom);
         step();
         total++; if (valid !== m_valid || gnt_oh !== exp_oh() || (m_valid && gnt_idx !== m_idx)) begin
            bad++;
            $display("FAIL rand cyc=%0d got=%b/%0d/%b want=%b/%0d/%b", c, valid, gnt_idx, gnt_oh, m_valid, m_idx, exp_oh());
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; ack = 1'b0; req = 8'd0;
      rst5 = 1'b1; ack5 = 1'b0; req5 = 5'd0;
      m_valid = 1'b0; m_idx = 3'd0; m_ptr = 3'd7;
      test_reset();
      test_idle();
`ifndef PRI_ENC_ARB_RR_EN
      test_fixed_starve();
`else
      test_rr_sweep();
`endif
      test_hold();
      test_reset_mid();
      test_n5();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
